// File: rtl/spi_slave_if.sv
// Host-side and SPI-pin bundle for spi_slave: serial pins, mode straps and the tx/rx byte handshake.
interface spi_slave_if #(
    parameter int DATA_BITS = 8
);
    logic                 cpol;
    logic                 cpha;
    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_load;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 tx_underrun;
    logic                 busy;

    modport slave (
        input  cpol, cpha, sclk, cs, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output cpol, cpha, sclk, cs, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder, all CPOL/CPHA modes: oversampled pins, MSB-first rx/tx shifting, one-deep tx buffer.
// Latency: pin change to detect SYNC_STAGES+1 clk; rx_valid one clk later. No backpressure: rx_data is overwritten.
module spi_slave #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic [0:0]             state;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-2:0]   rx_shift;
    logic [DATA_BITS-1:0]   tx_shift;
    logic [DATA_BITS-1:0]   buf_dat;
    logic                   buf_full;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   underrun_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead, trail, sample, update;
    logic start, run, last_bit, take;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign lead   = bus.cpol ? sclk_fall : sclk_rise;
    assign trail  = bus.cpol ? sclk_rise : sclk_fall;
    assign sample = bus.cpha ? trail : lead;
    assign update = bus.cpha ? lead  : trail;

    assign start    = (state == IDLE) && cs_fall;
    assign run      = (state == ACTIVE) && !cs_rise;
    assign last_bit = (bit_cnt == CW'(DATA_BITS - 1));
    // bit_cnt==0 on an update edge means a new byte begins: the first leading edge for
    // cpha=1, or the trailing edge right after the last sample for cpha=0.
    assign take = (start && !bus.cpha) || (run && update && (bit_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '0;
            mosi_sync  <= '0;
            sclk_d     <= 1'b0;
            cs_d       <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            buf_dat    <= '0;
            buf_full   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_d     <= sclk_s;
            cs_d       <= cs_s;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // A transfer in the same cycle as tx_load sees the old empty buffer.
            if (bus.tx_load && !buf_full) begin
                buf_dat  <= bus.tx_data;
                buf_full <= 1'b1;
            end else if (take) begin
                buf_full <= 1'b0;
            end

            if (take) begin
                tx_shift   <= buf_full ? buf_dat : '0;
                underrun_q <= !buf_full;
            end else if (start) begin
                tx_shift <= '0;
            end else if (run && update) begin
                tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (sample) begin
                        rx_shift <= {rx_shift[DATA_BITS-3:0], mosi_s};
                        if (last_bit) begin
                            rx_data_q  <= {rx_shift, mosi_s};
                            rx_valid_q <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.miso        = (state == ACTIVE) ? tx_shift[DATA_BITS-1] : 1'b0;
    assign bus.busy        = (state == ACTIVE);
    assign bus.tx_ready    = !buf_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a task-driven SPI master queues expected rx bytes; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_slave;
    localparam int DB = 8;
    localparam int H  = 80;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_BITS(DB)) bus();
    spi_slave #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;
    int underrun_cnt = 0;
    logic [DB-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_underrun) underrun_cnt++;
            if (bus.rx_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rx_unexpected: got rx_valid with 0x%0h, expected no word", bus.rx_data);
                end else begin
                    logic [DB-1:0] e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(e));
                end
            end
        end
    end

    task automatic set_mode(input logic p, input logic h);
        bus.cpol = p;
        bus.cpha = h;
        bus.sclk = p;
        #(2*H);
    endtask

    task automatic cs_begin();
        bus.cs = 1'b0;
        #(H);
    endtask

    task automatic cs_end();
        #(H);
        bus.cs = 1'b1;
        #(2*H);
    endtask

    task automatic xfer(input logic [DB-1:0] tx, input int nbits, output logic [DB-1:0] rx);
        rx = '0;
        for (int i = DB-1; i > DB-1-nbits; i--) begin
            if (!bus.cpha) begin
                bus.mosi = tx[i];
                #(H);
                bus.sclk = ~bus.cpol;
                rx[i] = bus.miso;
                #(H);
                bus.sclk = bus.cpol;
            end else begin
                bus.sclk = ~bus.cpol;
                bus.mosi = tx[i];
                #(H);
                bus.sclk = bus.cpol;
                rx[i] = bus.miso;
                #(H);
            end
        end
    endtask

    task automatic host_load(input logic [DB-1:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(bus.miso), 0);
        check({tag, "_tx_ready"}, 32'(bus.tx_ready), 1);
        check({tag, "_rx_data"},  32'(bus.rx_data), 0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
        check({tag, "_underrun"}, 32'(bus.tx_underrun), 0);
        check({tag, "_busy"},     32'(bus.busy), 0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] r, r1, r2;
        int u0;
        rst = 1'b1;
        bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.tx_load = 1'b0; bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Mode 0, single byte
        set_mode(1'b0, 1'b0);
        host_load(8'h3C);
        check("m0_ready_loaded", 32'(bus.tx_ready), 0);
        cs_begin();
        check("m0_ready_at_cs", 32'(bus.tx_ready), 1);
        check("m0_busy", 32'(bus.busy), 1);
        exp_q.push_back(8'hA5);
        xfer(8'hA5, 8, r);
        cs_end();
        check("m0_miso_byte", 32'(r), 32'h3C);

        // Mode 3, single byte
        set_mode(1'b1, 1'b1);
        host_load(8'h81);
        cs_begin();
        check("m3_miso_pre", 32'(bus.miso), 0);
        exp_q.push_back(8'h5A);
        xfer(8'h5A, 8, r);
        cs_end();
        check("m3_miso_byte", 32'(r), 32'h81);
        check("m3_miso_post", 32'(bus.miso), 0);
        check("m3_busy_post", 32'(bus.busy), 0);

        // Two bytes in one frame, mode 3
        u0 = underrun_cnt;
        host_load(8'hC3);
        cs_begin();
        exp_q.push_back(8'h11);
        xfer(8'h11, 8, r1);
        check("b2_ready_mid", 32'(bus.tx_ready), 1);
        host_load(8'h7E);
        exp_q.push_back(8'h22);
        xfer(8'h22, 8, r2);
        cs_end();
        check("b2_miso_1", 32'(r1), 32'hC3);
        check("b2_miso_2", 32'(r2), 32'h7E);
        check("b2_underruns", 32'(underrun_cnt - u0), 0);

        // Mode 1 with empty buffer
        set_mode(1'b0, 1'b1);
        u0 = underrun_cnt;
        cs_begin();
        exp_q.push_back(8'hF0);
        xfer(8'hF0, 8, r);
        cs_end();
        check("m1_miso_zero", 32'(r), 0);
        check("m1_underruns", 32'(underrun_cnt - u0), 1);

        // Aborted partial frame, then full frame
        set_mode(1'b0, 1'b0);
        cs_begin();
        xfer(8'hAA, 3, r);
        cs_end();
        cs_begin();
        exp_q.push_back(8'h0F);
        xfer(8'h0F, 8, r);
        cs_end();
        check("abort_rx_data", 32'(bus.rx_data), 32'h0F);

        // Reset mid-byte
        host_load(8'h55);
        cs_begin();
        xfer(8'h96, 4, r);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #(2*H);
        cs_begin();
        exp_q.push_back(8'h96);
        xfer(8'h96, 8, r);
        cs_end();
        check("rst_rx_data", 32'(bus.rx_data), 32'h96);
        check("rst_tx_ready", 32'(bus.tx_ready), 1);

        repeat (10) @(negedge clk);
        check("rx_pending", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder for the serial link driven by the team's SPI master. It oversamples sclk/cs/mosi on the system clock, deserialises MSB-first MOSI bytes and presents them as a 1-cycle rx_valid pulse. It also serialises a host-loaded transmit byte onto miso. All four CPOL/CPHA modes are supported, and consecutive bytes are allowed while cs stays low.

Parameters:
DATA_BITS, 8, bits per SPI word (MSB first)
SYNC_STAGES, 2, synchroniser flops on sclk, cs and mosi (min 2)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
cpol  in  1  sclk idle level; static while cs high
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while cs high
sclk  in  1  serial clock from master (asynchronous to clk)
cs  in  1  chip select, active low
mosi  in  1  master-out serial data
miso  out  1  slave-out serial data; 0 when cs high
tx_data  in  DATA_BITS  next byte to transmit
tx_load  in  1  write strobe for tx_data; honoured only when tx_ready=1
tx_ready  out  1  transmit buffer empty
rx_data  out  DATA_BITS  last complete received byte; held until the next byte completes
rx_valid  out  1  1-cycle pulse; rx_data updated
tx_underrun  out  1  1-cycle pulse; byte started with the buffer empty
busy  out  1  frame in progress (synchronised cs low)

Behaviour:
- Reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. Also clears the buffer, shift registers, bit counter, synchronisers and the FSM (IDLE). Reset mid-frame aborts immediately; no rx_valid is produced.
- Synchronisers: sclk_s, cs_s and mosi_s are taken from SYNC_STAGES flops. One extra register on sclk_s gives rise/fall detect.
- Edges: leading = transition away from cpol; trailing = transition back to cpol.
  - Sample edge: leading if cpha=0, trailing if cpha=1.
  - Update edge: the other one.
- Pin-to-detect latency: SYNC_STAGES+1 clk.
- Supported input: sclk high and low phases each >= 3 clk. Faster sclk is unsupported.
- FSM IDLE:
  - busy=0, miso=0.
  - On cs_s falling -> ACTIVE with bit_cnt=0 and busy=1.
  - If cpha=0, load the shift register from the buffer in the same cycle; miso then shows the MSB.
- FSM ACTIVE:
  - Sample edge: rx_shift <= {rx_shift[DATA_BITS-2:0], mosi_s}; bit_cnt++.
  - When the sample completes bit DATA_BITS-1:
    - rx_data <= the completed word; rx_valid pulses on the next clk.
    - bit_cnt wraps to 0; FSM stays ACTIVE.
  - Update edge, cpha=0: shift tx left. If that update edge follows the last sample of a byte, load the next byte instead of shifting.
  - Update edge, cpha=1: on the first leading edge of a byte, load the next byte (MSB onto miso); on later leading edges, shift left.
- Buffer load:
  - Taking the buffer into the shift register sets tx_ready=1 on the next clk.
  - If the buffer is empty at load time, load all-zeros and pulse tx_underrun.
- tx_load:
  - With tx_ready=1: capture tx_data; tx_ready=0 next clk.
  - With tx_ready=0: ignored.
  - In the same cycle as a buffer-to-shift transfer: the transfer takes the old (empty) state, so tx_underrun pulses; the new byte is captured and tx_ready=0.
- cs_s rising in ACTIVE (abort or normal end):
  - -> IDLE; a partial rx word is discarded and bit_cnt cleared.
  - A byte still in the buffer is kept for the next frame.
  - miso=0, busy=0.
- rx_data is unchanged by aborts.
- rx_valid asserts exactly once per complete word, even when the host ignores it (no backpressure; the next word overwrites).

Test Plan:
- Mode 0 (cpol=0, cpha=0), tx_load 0x3C before cs low; master sends 0xA5 -> rx_data=0xA5 with one rx_valid pulse; master receives 0x3C; tx_ready returns to 1 at cs fall.
- Mode 3 (cpol=1, cpha=1), tx 0x81; master sends 0x5A -> rx_data=0x5A; master receives 0x81; miso=0 before the first leading edge and after cs high.
- cs held low for 2 bytes (0x11, 0x22); host loads 0xC3 then 0x7E on tx_ready -> two rx_valid pulses (0x11 then 0x22); master receives 0xC3 then 0x7E; no tx_underrun.
- No tx_load before a frame in mode 1; master sends 0xF0 -> tx_underrun pulses once at byte start; miso stays 0 for 8 bits; rx_data=0xF0.
- cs raised after 3 sample edges of 0xAA, then a full 0x0F frame -> no rx_valid for the partial frame; the next frame gives rx_data=0x0F (stale bits not shifted in).
- rst asserted mid-byte, then a full frame 0x96 -> all outputs at reset values while rst=1; after release the frame gives rx_data=0x96 and tx_ready=1.
